// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: default geometry, reset PC and the NOP bubble word.
package fetch_queue_pkg;

    localparam int unsigned DEPTH_DEFAULT   = 4;
    localparam int unsigned PC_W_DEFAULT    = 16;
    localparam int unsigned INSTR_W_DEFAULT = 16;

    localparam logic [15:0] NOP_INSTR        = 16'h0000;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_fetch_fifo.sv
// Small PC+instruction FIFO with flush; head outputs read as zero/NOP when empty.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter int unsigned PC_W    = PC_W_DEFAULT,
    parameter int unsigned INSTR_W = INSTR_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [PC_W-1:0]            push_pc,
    input  logic [INSTR_W-1:0]         push_instr,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [PC_W-1:0]            head_pc,
    output logic [INSTR_W-1:0]         head_instr,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = PC_W + INSTR_W;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign head_valid = (count != '0);
    assign do_push    = push && !flush;
    assign do_pop     = pop && head_valid && !flush;
    assign level      = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: every read is qualified by head_valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_pc, push_instr};
    end

    always_comb begin
        head_pc    = '0;
        head_instr = INSTR_W'(NOP_INSTR);
        if (head_valid) {head_pc, head_instr} = mem[rd_ptr];
    end

endmodule

// File: rtl/fetch_queue.sv
// Prefetch stage: owns the fetch PC, issues sequential IM reads and buffers returned words for
// decode; redirects flush the buffer and squash the in-flight read via an epoch bit.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = DEPTH_DEFAULT,
    parameter int unsigned     PC_W     = PC_W_DEFAULT,
    parameter int unsigned     INSTR_W  = INSTR_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic                   im_rd_en,
    output logic [PC_W-1:0]        im_addr,
    input  logic [INSTR_W-1:0]     im_data,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INSTR_W-1:0]     id_instr,
    output logic [PC_W-1:0]        id_pc,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned        LVL_W   = level_width(DEPTH);
    localparam logic [LVL_W-1:0]   DEPTH_L = LVL_W'(DEPTH);

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  pend_pc;
    logic             inflight;
    logic             epoch;
    logic             pend_epoch;
    logic [LVL_W-1:0] fifo_level;
    logic [LVL_W-1:0] occupancy;
    logic             issue;
    logic             capture;
    logic             pop;

    // Counting the in-flight read against capacity guarantees every return has a free slot.
    assign occupancy = fifo_level + LVL_W'(inflight);
    assign issue     = rst && !redirect_valid && (occupancy < DEPTH_L);
    assign capture   = inflight && (pend_epoch == epoch) && !redirect_valid;
    assign pop       = id_valid && id_ready && !redirect_valid;

    assign im_rd_en  = issue;
    assign im_addr   = fetch_pc;
    assign level     = fifo_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC;
            pend_pc    <= '0;
            inflight   <= 1'b0;
            epoch      <= 1'b0;
            pend_epoch <= 1'b0;
        end else begin
            inflight <= issue;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                epoch    <= ~epoch;
            end else if (issue) begin
                fetch_pc   <= fetch_pc + 1'b1;
                pend_pc    <= fetch_pc;
                pend_epoch <= epoch;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (capture),
        .push_pc    (pend_pc),
        .push_instr (im_data),
        .pop        (pop),
        .head_valid (id_valid),
        .head_pc    (id_pc),
        .head_instr (id_instr),
        .level      (fifo_level)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; IM model returns 16'h1000 + address one cycle after a read.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        im_rd_en;
    logic [15:0] im_addr;
    logic [15:0] im_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [2:0]  level;

    int unsigned errors = 0;
    int unsigned checks = 0;

    fetch_queue #(
        .DEPTH    (4),
        .PC_W     (16),
        .INSTR_W  (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_rd_en       (im_rd_en),
        .im_addr        (im_addr),
        .im_data        (im_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .level          (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (im_rd_en) im_data <= 16'h1000 + im_addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart(input logic ready);
        rst = 1'b0;
        redirect_valid = 1'b0;
        id_ready = ready;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        id_ready = 1'b1;
        tick();
        tick();
        checks++; if (im_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b exp 0", im_rd_en); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", id_valid); end
        checks++; if (id_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h exp 0000", id_instr); end
        checks++; if (id_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h exp 0000", id_pc); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", level); end
    endtask

    task automatic test_stream;
        restart(1'b1);
        #1;
        checks++; if (im_rd_en !== 1'b1) begin errors++; $display("FAIL stream_first_rd: got %b exp 1", im_rd_en); end
        checks++; if (im_addr !== 16'h0000) begin errors++; $display("FAIL stream_first_addr: got %h exp 0000", im_addr); end
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: got valid %b exp 0", id_valid); end
        checks++; if (im_addr !== 16'h0001) begin errors++; $display("FAIL stream_addr1: got %h exp 0001", im_addr); end
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b exp 1", n, id_valid); end
            checks++; if (id_pc !== 16'(n)) begin errors++; $display("FAIL stream_pc[%0d]: got %h exp %h", n, id_pc, 16'(n)); end
            checks++; if (id_instr !== 16'h1000 + 16'(n)) begin errors++; $display("FAIL stream_instr[%0d]: got %h exp %h", n, id_instr, 16'h1000 + 16'(n)); end
            checks++; if (level !== 3'd1) begin errors++; $display("FAIL stream_level[%0d]: got %0d exp 1", n, level); end
        end
    endtask

    task automatic test_backpressure;
        restart(1'b0);
        repeat (6) tick();
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level_full: got %0d exp 4", level); end
        checks++; if (im_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_blocked: got %b exp 0", im_rd_en); end
        checks++; if (im_addr !== 16'h0004) begin errors++; $display("FAIL bp_fetch_pc: got %h exp 0004", im_addr); end
        id_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b exp 1", k, id_valid); end
            checks++; if (id_pc !== 16'(k)) begin errors++; $display("FAIL bp_pc[%0d]: got %h exp %h", k, id_pc, 16'(k)); end
            checks++; if (id_instr !== 16'h1000 + 16'(k)) begin errors++; $display("FAIL bp_instr[%0d]: got %h exp %h", k, id_instr, 16'h1000 + 16'(k)); end
            tick();
        end
    endtask

    task automatic test_redirect;
        restart(1'b0);
        repeat (3) tick();
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL rd_pre_level: got %0d exp 2", level); end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        checks++; if (im_rd_en !== 1'b0) begin errors++; $display("FAIL rd_no_issue: got %b exp 0", im_rd_en); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_flush_valid: got %b exp 0", id_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rd_flush_level: got %0d exp 0", level); end
        checks++; if (id_instr !== 16'h0000) begin errors++; $display("FAIL rd_flush_instr: got %h exp 0000", id_instr); end
        checks++; if (im_addr !== 16'h0040) begin errors++; $display("FAIL rd_target: got %h exp 0040", im_addr); end
        checks++; if (im_rd_en !== 1'b1) begin errors++; $display("FAIL rd_resume: got %b exp 1", im_rd_en); end
        id_ready = 1'b1;
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_stale: got valid %b pc %h exp invalid", id_valid, id_pc); end
        tick();
        checks++; if (id_pc !== 16'h0040 || id_valid !== 1'b1) begin errors++; $display("FAIL rd_first_pc: got %h/%b exp 0040/1", id_pc, id_valid); end
        checks++; if (id_instr !== 16'h1040) begin errors++; $display("FAIL rd_first_instr: got %h exp 1040", id_instr); end
        tick();
        checks++; if (id_pc !== 16'h0041) begin errors++; $display("FAIL rd_second_pc: got %h exp 0041", id_pc); end
    endtask

    task automatic test_redirect_pop_push;
        restart(1'b1);
        tick();
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 16'h0000) begin errors++; $display("FAIL rpp_head: got %b/%h exp 1/0000", id_valid, id_pc); end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rpp_level: got %0d exp 0", level); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rpp_valid: got %b exp 0", id_valid); end
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rpp_gap: got valid %b pc %h exp invalid", id_valid, id_pc); end
        tick();
        checks++; if (id_pc !== 16'h0040 || id_instr !== 16'h1040) begin errors++; $display("FAIL rpp_first: got %h/%h exp 0040/1040", id_pc, id_instr); end
        tick();
        checks++; if (id_pc !== 16'h0041) begin errors++; $display("FAIL rpp_next: got %h exp 0041", id_pc); end
    endtask

    task automatic test_wrap;
        restart(1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (im_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr_ffff: got %h exp ffff", im_addr); end
        tick();
        checks++; if (im_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr_0000: got %h exp 0000", im_addr); end
        tick();
        checks++; if (id_pc !== 16'hFFFF || id_instr !== 16'h0FFF) begin errors++; $display("FAIL wrap_pc_ffff: got %h/%h exp ffff/0fff", id_pc, id_instr); end
        tick();
        checks++; if (id_pc !== 16'h0000 || id_instr !== 16'h1000) begin errors++; $display("FAIL wrap_pc_0000: got %h/%h exp 0000/1000", id_pc, id_instr); end
    endtask

    task automatic test_mid_reset;
        restart(1'b0);
        repeat (4) tick();
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL mr_pre_level: got %0d exp 3", level); end
        rst = 1'b0;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mr_level: got %0d exp 0", level); end
        checks++; if (id_valid !== 1'b0 || id_pc !== 16'h0000 || id_instr !== 16'h0000) begin errors++; $display("FAIL mr_outputs: got %b/%h/%h exp 0/0000/0000", id_valid, id_pc, id_instr); end
        checks++; if (im_rd_en !== 1'b0) begin errors++; $display("FAIL mr_rd_en: got %b exp 0", im_rd_en); end
        tick();
        rst = 1'b1;
        id_ready = 1'b1;
        #1;
        checks++; if (im_addr !== 16'h0000 || im_rd_en !== 1'b1) begin errors++; $display("FAIL mr_restart: got %h/%b exp 0000/1", im_addr, im_rd_en); end
        tick();
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 16'h0000 || id_instr !== 16'h1000) begin errors++; $display("FAIL mr_first: got %b/%h/%h exp 1/0000/1000", id_valid, id_pc, id_instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_pop_push();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
